// File: rtl/slave_resp_router.sv
// slave_resp_router: routes slave ack and read-data responses back to the
// master that issued each request, using an ack-order queue of {id, cmd}
// and a data-order queue of read ids.
module slave_resp_router #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        perm0,
  input  logic        perm1,
  input  logic        cmd_to,
  input  logic        ack,
  input  logic        resp,
  input  logic [31:0] rdata,
  output logic        ack0,
  output logic        ack1,
  output logic        resp0,
  output logic        resp1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        full,
  output logic        busy,
  output logic        err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ack queue entry: bit 1 = master id, bit 0 = cmd (1 = write)
  logic [1:0]    r_aq [DEPTH];
  logic [PW-1:0] r_aq_wr, r_aq_rd;
  logic [CW-1:0] r_aq_cnt;

  logic          r_dq [DEPTH];
  logic [PW-1:0] r_dq_wr, r_dq_rd;
  logic [CW-1:0] r_dq_cnt;

  logic        r_ack0, r_ack1, r_resp0, r_resp1, r_err;
  logic [31:0] r_rdata0, r_rdata1;

  logic       w_aq_push_req, w_aq_push, w_aq_pop, w_aq_full;
  logic       w_dq_push_req, w_dq_push, w_dq_pop, w_dq_full;
  logic [1:0] w_aq_head;
  logic       w_dq_head;
  logic       w_err_set;

  // queue control: pops only see registered counts, so a read acked this
  // cycle cannot be answered by a resp in the same cycle
  always_comb begin
    w_aq_full     = (r_aq_cnt == FULL_CNT);
    w_dq_full     = (r_dq_cnt == FULL_CNT);
    w_aq_head     = r_aq[r_aq_rd];
    w_dq_head     = r_dq[r_dq_rd];
    w_aq_push_req = perm0 ^ perm1;
    w_aq_pop      = ack && (r_aq_cnt != '0);
    w_aq_push     = w_aq_push_req && (!w_aq_full || w_aq_pop);
    w_dq_push_req = w_aq_pop && !w_aq_head[0];
    w_dq_pop      = resp && (r_dq_cnt != '0);
    w_dq_push     = w_dq_push_req && (!w_dq_full || w_dq_pop);
    w_err_set     = (perm0 && perm1)
                  || (ack && (r_aq_cnt == '0))
                  || (resp && (r_dq_cnt == '0))
                  || (w_aq_push_req && !w_aq_push)
                  || (w_dq_push_req && !w_dq_push);
  end

  // ack queue storage, pointers and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_aq[i] <= '0;
      r_aq_wr  <= '0;
      r_aq_rd  <= '0;
      r_aq_cnt <= '0;
    end else begin
      if (w_aq_push) begin
        r_aq[r_aq_wr] <= {perm1, cmd_to};
        r_aq_wr       <= r_aq_wr + PW'(1);
      end
      if (w_aq_pop) r_aq_rd <= r_aq_rd + PW'(1);
      r_aq_cnt <= r_aq_cnt + CW'(w_aq_push) - CW'(w_aq_pop);
    end
  end

  // data queue storage, pointers and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_dq[i] <= 1'b0;
      r_dq_wr  <= '0;
      r_dq_rd  <= '0;
      r_dq_cnt <= '0;
    end else begin
      if (w_dq_push) begin
        r_dq[r_dq_wr] <= w_aq_head[1];
        r_dq_wr       <= r_dq_wr + PW'(1);
      end
      if (w_dq_pop) r_dq_rd <= r_dq_rd + PW'(1);
      r_dq_cnt <= r_dq_cnt + CW'(w_dq_push) - CW'(w_dq_pop);
    end
  end

  // routed ack/resp pulses, held read data and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_resp0  <= 1'b0;
      r_resp1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err    <= 1'b0;
    end else begin
      r_ack0  <= w_aq_pop && !w_aq_head[1];
      r_ack1  <= w_aq_pop &&  w_aq_head[1];
      r_resp0 <= w_dq_pop && !w_dq_head;
      r_resp1 <= w_dq_pop &&  w_dq_head;
      if (w_dq_pop && !w_dq_head) r_rdata0 <= rdata;
      if (w_dq_pop &&  w_dq_head) r_rdata1 <= rdata;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign resp0  = r_resp0;
  assign resp1  = r_resp1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;
  assign err    = r_err;
  assign full   = w_aq_full;
  assign busy   = (r_aq_cnt != '0) || (r_dq_cnt != '0);

endmodule

// File: tb/tb_slave_resp_router.sv
// tb_slave_resp_router: directed checks of response routing, queue limits,
// protocol errors and reset behaviour.
module tb_slave_resp_router;

  logic        clk, rst_n;
  logic        perm0, perm1, cmd_to, ack, resp;
  logic [31:0] rdata;
  logic        ack0, ack1, resp0, resp1, full, busy, err;
  logic [31:0] rdata0, rdata1;

  int unsigned npass = 0;
  int unsigned nchk  = 0;

  slave_resp_router #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .perm0(perm0), .perm1(perm1), .cmd_to(cmd_to),
    .ack(ack), .resp(resp), .rdata(rdata), .ack0(ack0), .ack1(ack1),
    .resp0(resp0), .resp1(resp1), .rdata0(rdata0), .rdata1(rdata1),
    .full(full), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // one clock with the given inputs; returns 1 time unit after the edge
  task automatic cyc(input logic p0, input logic p1, input logic c,
                     input logic a, input logic r, input logic [31:0] d);
    perm0 = p0; perm1 = p1; cmd_to = c; ack = a; resp = r; rdata = d;
    @(posedge clk);
    #1;
    perm0 = 0; perm1 = 0; cmd_to = 0; ack = 0; resp = 0; rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack0"}, ack0, 0);
    chk({tag, "_ack1"}, ack1, 0);
    chk({tag, "_resp0"}, resp0, 0);
    chk({tag, "_resp1"}, resp1, 0);
    chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_rdata1"}, rdata1, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    perm0 = 0; perm1 = 0; cmd_to = 0; ack = 0; resp = 0; rdata = '0;
    rst_n = 1'b0;
    #2;
    chk_all_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single read by M0
    cyc(1, 0, 0, 0, 0, 0);
    chk("rd_busy", busy, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("rd_ack0", ack0, 1);
    chk("rd_ack1", ack1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rd_ack0_pulse", ack0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hDEADBEEF);
    chk("rd_resp0", resp0, 1);
    chk("rd_resp1", resp1, 0);
    chk("rd_rdata0", rdata0, 32'hDEADBEEF);
    chk("rd_rdata1", rdata1, 0);
    chk("rd_busy_done", busy, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rd_resp0_pulse", resp0, 0);
    chk("rd_rdata0_hold", rdata0, 32'hDEADBEEF);

    // interleaved: M1 write, M0 read, M1 read
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("il_ack1_a", ack1, 1);
    chk("il_ack0_a", ack0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("il_ack0_b", ack0, 1);
    chk("il_ack1_b", ack1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("il_ack1_c", ack1, 1);
    chk("il_ack0_c", ack0, 0);
    cyc(0, 0, 0, 0, 1, 32'h1);
    chk("il_resp0", resp0, 1);
    chk("il_resp1_a", resp1, 0);
    chk("il_rdata0", rdata0, 32'h1);
    chk("il_rdata1_a", rdata1, 0);
    cyc(0, 0, 0, 0, 1, 32'h2);
    chk("il_resp1", resp1, 1);
    chk("il_resp0_b", resp0, 0);
    chk("il_rdata1", rdata1, 32'h2);
    chk("il_rdata0_hold", rdata0, 32'h1);
    chk("il_busy", busy, 0);
    chk("il_err", err, 0);

    // full queue
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("fu_full3", full, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("fu_full4", full, 1);
    cyc(1, 0, 1, 1, 0, 0);
    chk("fu_pp_ack0", ack0, 1);
    chk("fu_pp_full", full, 1);
    chk("fu_pp_err", err, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("fu_over_err", err, 1);
    chk("fu_over_full", full, 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("fu_drain3_busy", busy, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("fu_drain4_ack0", ack0, 1);
    chk("fu_drain4_busy", busy, 0);
    chk("fu_drain4_full", full, 0);

    // protocol errors
    do_reset();
    chk("pe_rst_err", err, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("pe_both_err", err, 1);
    chk("pe_both_busy", busy, 0);
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    chk("pe_eack_ack0", ack0, 0);
    chk("pe_eack_ack1", ack1, 0);
    chk("pe_eack_err", err, 1);
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    chk("pe_first_push_busy", busy, 1);
    cyc(0, 0, 0, 1, 1, 32'h55);
    chk("pe_same_ack0", ack0, 1);
    chk("pe_same_resp0", resp0, 0);
    chk("pe_same_err", err, 1);
    cyc(0, 0, 0, 0, 1, 32'h66);
    chk("pe_late_resp0", resp0, 1);
    chk("pe_late_rdata0", rdata0, 32'h66);

    // reset mid-operation with two reads outstanding
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("mr_ack0", ack0, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mr_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 1, 0, 0);
    chk("mr_ack0_after", ack0, 0);
    chk("mr_ack1_after", ack1, 0);
    chk("mr_err_ack", err, 1);
    cyc(0, 0, 0, 0, 1, 32'h77);
    chk("mr_resp0_after", resp0, 0);
    chk("mr_resp1_after", resp1, 0);
    chk("mr_rdata0_after", rdata0, 0);
    chk("mr_busy_after", busy, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/slave_resp_router.md
SLAVE_RESP_ROUTER -- requirements
Module: slave_resp_router

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the capacity of each outstanding-transaction queue (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports perm0, perm1  input  1 each  arbiter grant per master; a high level means a request was sent to the slave this cycle.
REQ-005 The block SHALL have port cmd_to  input  1  command of the granted request: 0 = read, 1 = write.
REQ-006 The block SHALL have port ack  input  1  slave acceptance pulse, one per request, in issue order.
REQ-007 The block SHALL have ports resp  input  1 and rdata  input  32, carrying the slave read-data valid flag and the read data, one per read, in ack order.
REQ-008 The block SHALL have ports ack0, ack1  output  1 each, carrying the routed acknowledge pulse per master.
REQ-009 The block SHALL have ports resp0, resp1  output  1 each and rdata0, rdata1  output  32 each, carrying routed read-data valid and data per master.
REQ-010 The block SHALL have port full  output  1, high when the ack queue holds DEPTH entries; the arbiter suppresses grants while it is high.
REQ-011 The block SHALL have port busy  output  1, high when either queue is non-empty.
REQ-012 The block SHALL have port err  output  1, a sticky protocol-error flag.

Function
REQ-013 The block SHALL keep an ack queue of {master id, cmd} entries and a data queue of master-id entries, both FIFO ordered, each holding DEPTH entries.
REQ-014 In a cycle where exactly one of perm0 and perm1 is high, the block SHALL push {id, cmd_to} into the ack queue (id 0 for perm0, 1 for perm1).
REQ-015 When perm0 and perm1 are both high, the block SHALL push nothing and SHALL set err.
REQ-016 When ack is high and the ack queue is non-empty, the block SHALL pop its head and SHALL pulse ack<id> high for exactly one cycle, on the next cycle (latency 1).
REQ-017 If the popped ack entry has cmd = 0, the block SHALL push its id into the data queue in the same cycle; a write entry (cmd = 1) completes at ack.
REQ-018 When resp is high and the data queue is non-empty, the block SHALL pop its head, register rdata into rdata<id>, and pulse resp<id> on the next cycle (latency 1).
REQ-019 rdata<id> SHALL hold its value until the next resp routed to that master; the other master's rdata SHALL stay unchanged.
REQ-020 An ack with an empty ack queue SHALL be ignored and SHALL set err.
REQ-021 A resp with an empty data queue SHALL be ignored and SHALL set err, including when an ack for a read arrives in the same cycle: data must follow its ack by at least one cycle.
REQ-022 A push and a pop on the same queue in the same cycle SHALL both take effect, including at full, and the count SHALL stay unchanged.
REQ-023 A push to a full queue with no simultaneous pop SHALL be dropped and SHALL set err.
REQ-024 Queue pointers SHALL wrap modulo DEPTH.
REQ-025 Counts SHALL be log2(DEPTH)+1 bits wide.
REQ-026 full and busy SHALL be derived from the registered counts, and SHALL reflect the state after the last clock edge.
REQ-027 err SHALL remain high until reset.
REQ-028 ack0/ack1 SHALL never be high in the same cycle, and resp0/resp1 SHALL never be high in the same cycle.

Reset
REQ-029 When rst_n is low, the block SHALL clear both queues and pointers, and SHALL drive all outputs to 0: ack0/1, resp0/1, rdata0/1 = 32'h0, full, busy, err.
REQ-030 A reset asserted mid-transaction SHALL discard all outstanding entries, and no ack or resp for them SHALL be produced after release.
REQ-031 The first push after reset release SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-032 The bench SHALL cover a read by M0: perm0=1, cmd_to=0; ack 2 cycles later -> ack0 pulse 1 cycle later; resp with rdata=32'hDEADBEEF 3 cycles after ack -> resp0=1, rdata0=32'hDEADBEEF, rdata1 unchanged, busy low afterwards.
REQ-033 The bench SHALL cover interleaved traffic: M1 write, M0 read, M1 read granted on consecutive cycles; three acks then resp 32'h1 and 32'h2 -> ack order ack1, ack0, ack1; resp0 with rdata0=1, then resp1 with rdata1=2.
REQ-034 The bench SHALL cover full: DEPTH=4 grants with no ack -> full=1; a 5th grant -> err=1, and ack count stays 4; a grant and an ack in the same cycle while full -> accepted, full remains 1, err unchanged.
REQ-035 The bench SHALL cover protocol errors: perm0=perm1=1 -> no push and err=1; ack on an empty queue -> no ack0/ack1 and err=1; resp in the same cycle as the read's ack -> dropped and err=1.
REQ-036 The bench SHALL cover reset mid-operation: 2 reads outstanding, rst_n low for 1 cycle -> all outputs 0; later ack/resp -> err=1 with no routed pulse.
